// File: rtl/pulse_period_meter.sv
// ---------------------------------------------------------------------------
// pulse_period_meter
//
// Measures the distance, in enabled clk cycles, between successive events on
// pulse_in. An event is any clk cycle in which both pulse_in and ena are high.
// When an event ends an interval, the interval's length is published on
// `period` and announced by a one-cycle `valid` strobe in the following cycle.
// Intervals longer than 2^N-1 cycles saturate. The block then raises
// `overflow` and drops that interval without reporting it. `locked` reports
// that the two most recent measurements were equal.
//
// Ports
//   clk       in   1   rising-edge clock for all state
//   rst_n     in   1   asynchronous, active-low reset
//   ena       in   1   measurement enable; when low, all state holds
//   pulse_in  in   1   event input, qualified by ena
//   period    out  N   last successfully measured event-to-event distance
//   valid     out  1   one-cycle strobe marking a new period value
//   overflow  out  1   high while the current interval exceeds 2^N-1 cycles
//   locked    out  1   high while the last two valid measurements were equal
// ---------------------------------------------------------------------------
module pulse_period_meter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic         pulse_in,
    output logic [N-1:0] period,
    output logic         valid,
    output logic         overflow,
    output logic         locked
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        OVF     = 2'd2
    } state_t;

    localparam logic [N-1:0] CountMax = '1;
    localparam logic [N-1:0] CountOne = {{(N-1){1'b0}}, 1'b1};

    state_t         state_q,     state_d;
    logic [N-1:0]   count_q,     count_d;
    logic [N-1:0]   period_q,    period_d;
    logic [N-1:0]   prev_q,      prev_d;
    logic           prevValid_q, prevValid_d;
    logic           valid_q,     valid_d;
    logic           overflow_q,  overflow_d;
    logic           locked_q,    locked_d;

    // State register. Every output comes straight from a flop here, so no
    // output depends combinationally on pulse_in or ena.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            period_q    <= '0;
            prev_q      <= '0;
            prevValid_q <= 1'b0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            period_q    <= period_d;
            prev_q      <= prev_d;
            prevValid_q <= prevValid_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
            locked_q    <= locked_d;
        end
    end

    // Next-state logic. Everything holds by default and valid defaults low,
    // so a cycle with ena low freezes the measurement and emits no strobe.
    // The count starts at 1 in the cycle after an event. When the next event
    // arrives, count therefore equals t1-t0, with cycles frozen by ena
    // excluded.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        period_d    = period_q;
        prev_d      = prev_q;
        prevValid_d = prevValid_q;
        valid_d     = 1'b0;
        overflow_d  = overflow_q;
        locked_d    = locked_q;

        if (ena) begin
            case (state_q)
                IDLE: begin
                    if (pulse_in) begin
                        state_d = MEASURE;
                        count_d = CountOne;
                    end
                end

                MEASURE: begin
                    if (pulse_in) begin
                        // Close the interval. locked needs a previous
                        // measurement that is still trustworthy, meaning
                        // there has been no overflow since it was taken.
                        period_d    = count_q;
                        valid_d     = 1'b1;
                        count_d     = CountOne;
                        prev_d      = count_q;
                        prevValid_d = 1'b1;
                        locked_d    = prevValid_q && (count_q == prev_q);
                    end else if (count_q == CountMax) begin
                        // Reaching CountMax is legal because an event here
                        // reports 2^N-1. One more empty cycle saturates.
                        state_d     = OVF;
                        overflow_d  = 1'b1;
                        locked_d    = 1'b0;
                        prev_d      = '0;
                        prevValid_d = 1'b0;
                    end else begin
                        count_d = count_q + CountOne;
                    end
                end

                OVF: begin
                    // The saturated interval is discarded. The event only
                    // starts a fresh one.
                    if (pulse_in) begin
                        state_d    = MEASURE;
                        count_d    = CountOne;
                        overflow_d = 1'b0;
                    end
                end

                default: begin
                    state_d     = IDLE;
                    count_d     = '0;
                    overflow_d  = 1'b0;
                    locked_d    = 1'b0;
                    prevValid_d = 1'b0;
                end
            endcase
        end
    end

    assign period   = period_q;
    assign valid    = valid_q;
    assign overflow = overflow_q;
    assign locked   = locked_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// ---------------------------------------------------------------------------
// tb_pulse_period_meter
//
// Directed scenarios followed by randomized periodic pulse trains for
// pulse_period_meter (N=8). A behavioural model tracks the elapsed enabled
// cycles since the last event as an unbounded integer. It keeps a short
// history of reported periods and predicts all four outputs after every
// clock edge.
// ---------------------------------------------------------------------------
module tb_pulse_period_meter;

    localparam int N = 8;
    localparam int MaxPeriod = (1 << N) - 1;

    logic         clk;
    logic         rst_n;
    logic         ena;
    logic         pulse_in;
    logic [N-1:0] period;
    logic         valid;
    logic         overflow;
    logic         locked;

    int compared;
    int mismatched;

    // Reference model state.
    bit mHave;
    int mElapsed;
    int mPeriod;
    bit mValid;
    bit mOverflow;
    bit mLocked;
    int mHist[$];

    int segPeriod;
    int segReps;
    bit segDrop;
    int strobes;

    pulse_period_meter #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .pulse_in (pulse_in),
        .period   (period),
        .valid    (valid),
        .overflow (overflow),
        .locked   (locked)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value and count it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Return the model to its post-reset condition.
    task automatic resetModel();
        mHave     = 1'b0;
        mElapsed  = 0;
        mPeriod   = 0;
        mValid    = 1'b0;
        mOverflow = 1'b0;
        mLocked   = 1'b0;
        mHist.delete();
    endtask

    // Drive one cycle, advance the model for that cycle, then compare all
    // outputs 1 ns after the edge.
    task automatic applyStimulus(input logic e, input logic p);
        ena      = e;
        pulse_in = p;
        @(posedge clk);
        mValid = 1'b0;
        if (e) begin
            if (p) begin
                if (mHave && mElapsed <= MaxPeriod) begin
                    mPeriod = mElapsed;
                    mValid  = 1'b1;
                    mHist.push_back(mElapsed);
                    if (mHist.size() > 2) void'(mHist.pop_front());
                    mLocked = (mHist.size() == 2) && (mHist[0] == mHist[1]);
                end
                mOverflow = 1'b0;
                mHave     = 1'b1;
                mElapsed  = 1;
            end else if (mHave) begin
                mElapsed++;
                if (mElapsed > MaxPeriod) begin
                    mOverflow = 1'b1;
                    mLocked   = 1'b0;
                    mHist.delete();
                end
            end
        end
        #1;
        checkOutput("model_period",   32'(period),   32'(mPeriod));
        checkOutput("model_valid",    32'(valid),    32'(mValid));
        checkOutput("model_overflow", 32'(overflow), 32'(mOverflow));
        checkOutput("model_locked",   32'(locked),   32'(mLocked));
    endtask

    // Pulse rst_n between clock edges. All outputs must be 0 before the next
    // edge arrives. The task is entered 1 ns after a rising edge.
    task automatic resetMidCycle(input string tag);
        #1 rst_n = 1'b0;
        #1;
        checkOutput({tag, "_period"},   32'(period),   32'd0);
        checkOutput({tag, "_valid"},    32'(valid),    32'd0);
        checkOutput({tag, "_overflow"}, 32'(overflow), 32'd0);
        checkOutput({tag, "_locked"},   32'(locked),   32'd0);
        resetModel();
        #1 rst_n = 1'b1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        ena        = 1'b0;
        pulse_in   = 1'b0;
        resetModel();

        // Power-on reset spans the first clock edge.
        #12;
        checkOutput("por_period",   32'(period),   32'd0);
        checkOutput("por_valid",    32'(valid),    32'd0);
        checkOutput("por_overflow", 32'(overflow), 32'd0);
        checkOutput("por_locked",   32'(locked),   32'd0);
        #2 rst_n = 1'b1;

        // Events in cycles 10, 15 and 20.
        idleCycles(10);
        applyStimulus(1'b1, 1'b1);
        idleCycles(4);
        applyStimulus(1'b1, 1'b1);
        checkOutput("s1_valid16",  32'(valid),  32'd1);
        checkOutput("s1_period16", 32'(period), 32'd5);
        checkOutput("s1_locked16", 32'(locked), 32'd0);
        idleCycles(4);
        applyStimulus(1'b1, 1'b1);
        checkOutput("s1_valid21",  32'(valid),  32'd1);
        checkOutput("s1_period21", 32'(period), 32'd5);
        checkOutput("s1_locked21", 32'(locked), 32'd1);
        idleCycles(1);
        checkOutput("s1_valid22",  32'(valid),  32'd0);
        checkOutput("s1_locked22", 32'(locked), 32'd1);

        // Events in cycles 0 and 255 give the largest reportable period.
        resetMidCycle("rst_a");
        applyStimulus(1'b1, 1'b1);
        idleCycles(254);
        applyStimulus(1'b1, 1'b1);
        checkOutput("s2_valid",    32'(valid),    32'd1);
        checkOutput("s2_period",   32'(period),   32'd255);
        checkOutput("s2_overflow", 32'(overflow), 32'd0);

        // A lone event saturates the interval, and a later event recovers.
        resetMidCycle("rst_b");
        applyStimulus(1'b1, 1'b1);
        idleCycles(254);
        checkOutput("s3_ovf255", 32'(overflow), 32'd0);
        idleCycles(1);
        checkOutput("s3_ovf256",    32'(overflow), 32'd1);
        checkOutput("s3_locked256", 32'(locked),   32'd0);
        idleCycles(44);
        applyStimulus(1'b1, 1'b1);
        checkOutput("s3_valid301", 32'(valid),    32'd0);
        checkOutput("s3_ovf301",   32'(overflow), 32'd0);
        idleCycles(6);
        applyStimulus(1'b1, 1'b1);
        checkOutput("s3_valid308",  32'(valid),  32'd1);
        checkOutput("s3_period308", 32'(period), 32'd7);
        checkOutput("s3_locked308", 32'(locked), 32'd0);

        // Events in cycles 0 and 10 with ena low in cycles 3-6. pulse_in is
        // held high during the freeze to show that it is ignored.
        resetMidCycle("rst_c");
        applyStimulus(1'b1, 1'b1);
        idleCycles(2);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1);
            checkOutput("s4_frozen_valid", 32'(valid), 32'd0);
        end
        idleCycles(3);
        applyStimulus(1'b1, 1'b1);
        checkOutput("s4_valid",  32'(valid),  32'd1);
        checkOutput("s4_period", 32'(period), 32'd6);

        // pulse_in held high for 5 cycles.
        resetMidCycle("rst_d");
        strobes = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1);
            if (valid) strobes++;
            if (i == 1) checkOutput("s5_locked_first", 32'(locked), 32'd0);
            if (i >= 2) checkOutput("s5_locked_later", 32'(locked), 32'd1);
            if (i >= 1) checkOutput("s5_period",       32'(period), 32'd1);
        end
        applyStimulus(1'b1, 1'b0);
        if (valid) strobes++;
        checkOutput("s5_strobes", 32'(strobes), 32'd4);

        // Reset mid-interval. The next two events, 4 cycles apart, give a
        // single unlocked measurement. The first event lands on the first
        // edge after release.
        idleCycles(2);
        resetMidCycle("s6_rst");
        applyStimulus(1'b1, 1'b1);
        checkOutput("s6_valid_start", 32'(valid), 32'd0);
        idleCycles(3);
        applyStimulus(1'b1, 1'b1);
        checkOutput("s6_valid",  32'(valid),  32'd1);
        checkOutput("s6_period", 32'(period), 32'd4);
        checkOutput("s6_locked", 32'(locked), 32'd0);

        // Randomized periodic trains. Some are long enough to saturate, and
        // some have enable dropouts.
        resetMidCycle("rst_r");
        for (int seg = 0; seg < 24; seg++) begin
            segPeriod = ($urandom_range(0, 3) == 0) ? int'($urandom_range(240, 270))
                                                     : int'($urandom_range(1, 12));
            segReps   = int'($urandom_range(2, 5));
            segDrop   = ($urandom_range(0, 2) == 0);
            for (int r = 0; r < segReps; r++) begin
                for (int c = 0; c < segPeriod; c++) begin
                    applyStimulus(segDrop ? ($urandom_range(0, 7) != 0) : 1'b1, c == 0);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
